// File: rtl/noc_sa_pkg.sv
// Shared definitions for the age-based switch allocator: default sizes and
// helpers that pack/unpack the per-input destination fields of a flat vector.
// Helpers work on maximum-width containers (16 ports) so any legal N fits.
package noc_sa_pkg;

    localparam int N_DEF     = 7;
    localparam int AGE_W_DEF = 3;
    localparam int DW_DEF    = $clog2(N_DEF + 1);

    localparam int N_MAX   = 16;
    localparam int DW_MAX  = $clog2(N_MAX + 1);
    localparam int VEC_MAX = N_MAX * DW_MAX;

    typedef logic [DW_MAX-1:0]  dest_t;
    typedef logic [VEC_MAX-1:0] dest_vec_t;

    // Low dw bits set.
    function automatic dest_t dest_mask(input int dw);
        return dest_t'((1 << dw) - 1);
    endfunction

    // Extract destination field idx of width dw.
    function automatic dest_t dest_get(input dest_vec_t vec, input int dw, input int idx);
        dest_vec_t sh;
        sh = vec >> (dw * idx);
        return sh[DW_MAX-1:0] & dest_mask(dw);
    endfunction

    // Return vec with destination field idx replaced by d.
    function automatic dest_vec_t dest_put(input dest_vec_t vec, input int dw, input int idx,
                                           input dest_t d);
        dest_vec_t field_mask;
        dest_vec_t field;
        field_mask = dest_vec_t'(dest_mask(dw)) << (dw * idx);
        field      = dest_vec_t'(d & dest_mask(dw)) << (dw * idx);
        return (vec & ~field_mask) | field;
    endfunction

    // A destination is a real request only when it names an existing output.
    function automatic logic dest_valid(input dest_t d, input int n);
        return (d != '0) && (int'(d) <= n);
    endfunction

endpackage

// File: rtl/switch_alloc_age_if.sv
// Request/grant bundle between the input units and the switch allocator.
// master: input-unit side (drives requests, pops); slave: allocator side.
interface switch_alloc_age_if
    import noc_sa_pkg::*;
#(
    parameter int N = N_DEF
);
    localparam int DW = $clog2(N + 1);

    logic [N*DW-1:0] req_dest;
    logic [N-1:0]    pop;
    logic [N-1:0]    tail;
    logic [N*DW-1:0] grant_dest;
    logic [N-1:0]    lock_vec;

    modport master (
        output req_dest,
        output pop,
        output tail,
        input  grant_dest,
        input  lock_vec
    );

    modport slave (
        input  req_dest,
        input  pop,
        input  tail,
        output grant_dest,
        output lock_vec
    );
endinterface

// File: rtl/sa_out_arb.sv
// Per-output selector: picks the input with the largest non-zero priority,
// the lowest index winning ties. Purely combinational.
module sa_out_arb
    import noc_sa_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int AGE_W = AGE_W_DEF,
    parameter int IW    = $clog2(N)
) (
    input  logic [N*AGE_W-1:0] prio,
    output logic [IW-1:0]      win_idx,
    output logic               win_valid
);

    logic [AGE_W-1:0] prio_a [N];
    logic [AGE_W-1:0] best_prio;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign prio_a[gi] = prio[AGE_W*gi +: AGE_W];
    end

    // Strictly-greater scan so an equal later input never displaces an earlier one.
    always_comb begin
        best_prio = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (prio_a[i] > best_prio) begin
                best_prio = prio_a[i];
                win_idx   = IW'(i);
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_alloc_age.sv
// Age-priority switch allocator with registered grants.
// Each output goes to the oldest requesting input (popping inputs count as
// age 1); ties go to the lowest index. With SWITCH_ALLOC_LOCK_EN defined, a
// granted output stays locked to its winner (wormhole) until the owner pops
// a tail flit or stops requesting it; otherwise every output is re-arbitrated
// each cycle and lock_vec reads 0.
module switch_alloc_age
    import noc_sa_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int AGE_W = AGE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    switch_alloc_age_if.slave bus
);

    localparam int               DW      = $clog2(N + 1);
    localparam int               IW      = $clog2(N);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

    dest_vec_t          req_vec;
    dest_t              req_d [N];
    logic [N-1:0]       req_v;
    logic [AGE_W-1:0]   age_reg [N];
    logic [AGE_W-1:0]   age_next [N];
    logic [AGE_W-1:0]   eff [N];
    logic [N*AGE_W-1:0] prio_flat [N];
    logic [IW-1:0]      win_idx [N];
    logic [N-1:0]       win_valid;
    dest_vec_t          grant_vec;
    logic [N*DW-1:0]    grant_next;
    logic [N*DW-1:0]    grant_reg;

`ifdef SWITCH_ALLOC_LOCK_EN
    logic [N-1:0]  lock_reg;
    logic [N-1:0]  lock_next;
    logic [IW-1:0] owner_reg [N];
    logic [IW-1:0] owner_next [N];
`endif

    assign req_vec = dest_vec_t'(bus.req_dest);

    // Per-input request decode and effective priority.
    for (genvar gi = 0; gi < N; gi++) begin : g_in
        assign req_d[gi] = dest_get(req_vec, DW, gi);
        assign req_v[gi] = dest_valid(req_d[gi], N);
        assign eff[gi]   = bus.pop[gi] ? AGE_ONE : age_reg[gi];
    end

    // Per-output priority vectors and selectors. A locked output only sees
    // its owner, so in a release cycle nobody else can win it.
    for (genvar go = 0; go < N; go++) begin : g_out
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            logic hit;
            assign hit = req_v[gi] && (req_d[gi] == dest_t'(go + 1));
`ifdef SWITCH_ALLOC_LOCK_EN
            assign prio_flat[go][AGE_W*gi +: AGE_W] =
                (hit && (!lock_reg[go] || (owner_reg[go] == IW'(gi)))) ? eff[gi] : '0;
`else
            assign prio_flat[go][AGE_W*gi +: AGE_W] = hit ? eff[gi] : '0;
`endif
        end

        sa_out_arb #(
            .N     (N),
            .AGE_W (AGE_W),
            .IW    (IW)
        ) u_arb (
            .prio      (prio_flat[go]),
            .win_idx   (win_idx[go]),
            .win_valid (win_valid[go])
        );
    end

    // Age update: restart at 1 on pop, otherwise count up and stick at max.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (bus.pop[i]) begin
                age_next[i] = AGE_ONE;
            end else if (age_reg[i] == AGE_MAX) begin
                age_next[i] = AGE_MAX;
            end else begin
                age_next[i] = age_reg[i] + AGE_ONE;
            end
        end
    end

    // Age counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                age_reg[i] <= AGE_ONE;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                age_reg[i] <= age_next[i];
            end
        end
    end

    // Scatter output winners back into per-input grant fields. Each input
    // requests a single output, so no field is written twice.
    always_comb begin
        grant_vec = '0;
        for (int o = 0; o < N; o++) begin
            if (win_valid[o]) begin
                grant_vec = dest_put(grant_vec, DW, int'(win_idx[o]), dest_t'(o + 1));
            end
        end
    end

    assign grant_next = grant_vec[N*DW-1:0];

    // Grant register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_reg <= '0;
        end else begin
            grant_reg <= grant_next;
        end
    end

    assign bus.grant_dest = grant_reg;

`ifdef SWITCH_ALLOC_LOCK_EN
    // Lock tracking: a held output drops when its owner finishes the packet or
    // turns away; a free output locks to a winner that is not a one-flit packet.
    always_comb begin
        for (int o = 0; o < N; o++) begin
            lock_next[o]  = lock_reg[o];
            owner_next[o] = owner_reg[o];
            if (lock_reg[o]) begin
                if (!(req_v[owner_reg[o]] && (req_d[owner_reg[o]] == dest_t'(o + 1))) ||
                    (bus.pop[owner_reg[o]] && bus.tail[owner_reg[o]])) begin
                    lock_next[o] = 1'b0;
                end
            end else if (win_valid[o] && !(bus.pop[win_idx[o]] && bus.tail[win_idx[o]])) begin
                lock_next[o]  = 1'b1;
                owner_next[o] = win_idx[o];
            end
        end
    end

    // Lock state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_reg <= '0;
            for (int o = 0; o < N; o++) begin
                owner_reg[o] <= '0;
            end
        end else begin
            lock_reg <= lock_next;
            for (int o = 0; o < N; o++) begin
                owner_reg[o] <= owner_next[o];
            end
        end
    end

    assign bus.lock_vec = lock_reg;
`else
    // Tail only matters for locking; without it the flag is ignored.
    logic [N-1:0] unused_tail;
    assign unused_tail  = bus.tail;
    assign bus.lock_vec = '0;
`endif

endmodule
